// File: rtl/mw_pipe_reg.sv
// rtl/mw_pipe_reg.sv - Execute->Memory/Writeback pipeline register with flush and stall counter
// Define MW_PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module mw_pipe_reg #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              accept;
   logic              drain;

   assign out_valid = (state_q != ST_EMPTY);
   // Bubbles must never expose stale write enables downstream.
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign out_data  = main_data_q;
   assign stall_cnt = stall_q;
   assign drain     = out_valid && out_ready;
   assign accept    = in_valid && in_ready && !flush;

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

`ifdef MW_PIPE_SKID_EN
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   // Decoded straight from the state flop, so no path from out_ready.
   assign in_ready = (state_q != ST_FULL);

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
               state_d     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (accept && drain) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
            end else if (accept) begin
               skid_ctrl_d = in_ctrl;
               skid_data_d = in_data;
               state_d     = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               main_ctrl_d = skid_ctrl_q;
               main_data_d = skid_data_q;
               state_d     = ST_BUSY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      if (accept) begin
         main_ctrl_d = in_ctrl;
         main_data_d = in_data;
         state_d     = ST_BUSY;
      end else if (drain) begin
         state_d = ST_EMPTY;
      end
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         stall_q     <= stall_d;
      end
   end

endmodule

// File: tb/tb_mw_pipe_reg.sv
// tb/tb_mw_pipe_reg.sv - self-checking bench for mw_pipe_reg
// Works with and without MW_PIPE_SKID_EN defined.
module tb_mw_pipe_reg;

   localparam int DATA_W = 160;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, out_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;
   logic              in_ready4, out_valid4;
   logic [CTRL_W-1:0] out_ctrl4;
   logic [DATA_W-1:0] out_data4;
   logic [3:0]        stall_cnt4;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [CTRL_W+DATA_W-1:0] sb[$];
   logic [CTRL_W+DATA_W-1:0] exp_beat;

   always #5 clk = ~clk;

   mw_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt));

   mw_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
      .out_ctrl(out_ctrl4), .out_data(out_data4), .stall_cnt(stall_cnt4));

   // Scoreboard: push on accept, pop/compare on drain, flush/rst kill held beats.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (!out_valid) begin
            total_cnt++;
            if (out_ctrl !== '0) $display("FAIL bubble_ctrl: got %0h want 0", out_ctrl);
            else pass_cnt++;
         end
         if (out_valid && out_ready) begin
            total_cnt++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected: got ctrl=%0h data=%0h want no beat", out_ctrl, out_data);
            end else begin
               exp_beat = sb.pop_front();
               if ({out_ctrl, out_data} !== exp_beat)
                  $display("FAIL sb_order: got %0h want %0h", {out_ctrl, out_data}, exp_beat);
               else pass_cnt++;
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
      step(); step();
      rst = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_ctrl !== '0) $display("FAIL reset_out_ctrl: got %0h want 0", out_ctrl); else pass_cnt++;
      total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %0h want 0", out_data); else pass_cnt++;
      total_cnt++; if (stall_cnt !== '0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      total_cnt++; if (out_ctrl !== '0) $display("FAIL stream_ctrl0: got %0h want 0", out_ctrl); else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(8'h10 + i);
         step();
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d: got %0b want 1", i, out_valid); else pass_cnt++;
         total_cnt++; if (out_data !== DATA_W'(i)) $display("FAIL stream_data%0d: got %0h want %0h", i, out_data, i); else pass_cnt++;
      end
      in_valid = 1'b0;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_end_valid: got %0b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== DATA_W'(3)) $display("FAIL stream_hold_data: got %0h want 3", out_data); else pass_cnt++;
      total_cnt++; if (stall_cnt !== '0) $display("FAIL stream_stall: got %0d want 0", stall_cnt); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [CNT_W-1:0] s0;
      s0 = stall_cnt;
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hA1; in_data = DATA_W'(32'hA);
      step();
`ifdef MW_PIPE_SKID_EN
      in_ctrl = 8'hB1; in_data = DATA_W'(32'hB);
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_busy: got %0b want 1", in_ready); else pass_cnt++;
      step();
      in_valid = 1'b0;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %0b want 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_data !== DATA_W'(32'hA)) $display("FAIL bp_head_a: got %0h want a", out_data); else pass_cnt++;
      step(); step();
      total_cnt++; if (out_data !== DATA_W'(32'hA)) $display("FAIL bp_stable_a: got %0h want a", out_data); else pass_cnt++;
      out_ready = 1'b1;
      step();
      total_cnt++; if (out_data !== DATA_W'(32'hB)) $display("FAIL bp_head_b: got %0h want b", out_data); else pass_cnt++;
      step();
      total_cnt++; if (stall_cnt !== s0 + CNT_W'(3)) $display("FAIL bp_stall: got %0d want %0d", stall_cnt, s0 + CNT_W'(3)); else pass_cnt++;
`else
      in_ctrl = 8'hB1; in_data = DATA_W'(32'hB);
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_held: got %0b want 0", in_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_data !== DATA_W'(32'hA)) $display("FAIL bp_stable_a: got %0h want a", out_data); else pass_cnt++;
      out_ready = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_comb: got %0b want 1", in_ready); else pass_cnt++;
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_data !== DATA_W'(32'hB)) $display("FAIL bp_replace_b: got %0h want b", out_data); else pass_cnt++;
      step();
      total_cnt++; if (stall_cnt !== s0 + CNT_W'(1)) $display("FAIL bp_stall: got %0d want %0d", stall_cnt, s0 + CNT_W'(1)); else pass_cnt++;
`endif
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %0b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] s0;
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h55; in_data = DATA_W'(32'h5);
      step();
`ifdef MW_PIPE_SKID_EN
      in_ctrl = 8'h66; in_data = DATA_W'(32'h6);
      step();
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_full: got %0b want 0", in_ready); else pass_cnt++;
`endif
      s0 = stall_cnt;
      out_ready = 1'b1; flush = 1'b1; in_ctrl = 8'hCC; in_data = DATA_W'(32'hC);
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_ctrl !== '0) $display("FAIL flush_ctrl: got %0h want 0", out_ctrl); else pass_cnt++;
      total_cnt++; if (stall_cnt !== s0) $display("FAIL flush_stall: got %0d want %0d", stall_cnt, s0); else pass_cnt++;
      flush = 1'b0; in_valid = 1'b0;
      step(); step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_no_c: got %0b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %0b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_rst_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h77; in_data = DATA_W'(32'h7);
      step();
      in_ctrl = 8'h88; in_data = DATA_W'(32'h8);
      step();
      rst = 1'b1; flush = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rf_valid: got %0b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_ctrl !== '0) $display("FAIL rf_ctrl: got %0h want 0", out_ctrl); else pass_cnt++;
      total_cnt++; if (out_data !== '0) $display("FAIL rf_data: got %0h want 0", out_data); else pass_cnt++;
      total_cnt++; if (stall_cnt !== '0) $display("FAIL rf_stall: got %0d want 0", stall_cnt); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rf_ready: got %0b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_saturate();
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = DATA_W'(32'h55);
      step();
      in_valid = 1'b0;
      repeat (20) step();
      total_cnt++; if (stall_cnt4 !== 4'd15) $display("FAIL sat_cnt4: got %0d want 15", stall_cnt4); else pass_cnt++;
      total_cnt++; if (stall_cnt !== CNT_W'(20)) $display("FAIL sat_cnt16: got %0d want 20", stall_cnt); else pass_cnt++;
      total_cnt++; if (out_valid4 !== 1'b1 || out_data4 !== DATA_W'(32'h55) || out_ctrl4 !== 8'h5A || in_ready4 !== in_ready)
         $display("FAIL sat_held4: got v=%0b d=%0h c=%0h want v=1 d=55 c=5a", out_valid4, out_data4, out_ctrl4); else pass_cnt++;
      out_ready = 1'b1;
      step(); step();
      total_cnt++; if (stall_cnt4 !== 4'd15) $display("FAIL sat_hold4: got %0d want 15", stall_cnt4); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ctrl   = 8'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step(); step();
      total_cnt++; if (sb.size() != 0) $display("FAIL b2b_left: got %0d beats want 0", sb.size()); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %0b want 0", out_valid); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_rst_flush();
      test_saturate();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mw_pipe_reg.md
# mw_pipe_reg

Parametrised Execute→Memory/Writeback pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between the execute stage and the memory/writeback stage and carries a control field and a data payload per instruction. Bubbles always present an all-zero control field so write enables can never fire spuriously. A saturating counter reports downstream back-pressure cycles for performance analysis.

## Interface
Parameters:
- DATA_W, 160: payload width (e.g. PC, ALU result, store data, operand A, immediate).
- CTRL_W, 8: control width (register write address, CSR read/write enables, etc.); zeroed on bubbles.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts the beat this cycle (low = stall).
- out_ctrl  out  CTRL_W  control of head entry; 0 when out_valid=0.
- out_data  out  DATA_W  payload of head entry.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready && !flush. Drain: out_valid && out_ready.
- Strict in-order delivery; no beat is dropped or duplicated except by flush/rst.
- Skid mode states: EMPTY (no entries), BUSY (main only), FULL (main + skid).
  - EMPTY: accept → BUSY.
  - BUSY: accept & drain → BUSY (main loads new beat); accept only → FULL (beat to skid); drain only → EMPTY.
  - FULL: in_ready=0; drain → BUSY (skid moves to main).
- Non-skid mode: single entry; in_ready = !out_valid || out_ready (combinational); accept and drain in the same cycle replaces the entry.
- flush: next cycle all entries invalid, state EMPTY; any beat offered in the flush cycle is discarded; an out handshake in the flush cycle still counts as delivered.
- rst has priority over flush.
- out_ctrl is forced to 0 whenever out_valid=0; out_data holds its last value while invalid.
- stall_cnt increments once per cycle with out_valid && !out_ready, saturates at all-ones, and clears only on rst (not on flush).

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, state EMPTY, in_ready=1.
- Latency: beat accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Skid mode: in_ready is a pure register output (= state≠FULL); no in/out combinational path.
- Non-skid mode: out_ready→in_ready is combinational.
- Back-pressure: out_valid, out_ctrl and out_data stay stable while out_valid && !out_ready (unless flush/rst).

## Configuration
- MW_PIPE_SKID_EN defined: two-entry skid buffer with FSM above; registered in_ready.
- MW_PIPE_SKID_EN undefined: single-entry register; combinational in_ready; no FULL state.
- All other behaviour (flush, bubble zeroing, stall_cnt) is identical in both builds.

## Test plan
- Reset then stream beats data=1,2,3 with out_ready=1 → out_data 1,2,3 in cycles 1,2,3 after each accept; out_ctrl=0 in cycle 0; stall_cnt=0.
- Skid build: send A,B with out_ready=0 → in_ready drops to 0 after B; raise out_ready → A then B delivered in order; stall_cnt equals the number of held cycles (e.g. 3).
- Non-skid build: entry held, out_ready=0 → in_ready=0 in the same cycle; out_ready=1 with in_valid=1 → replacement, in_ready=1 combinationally.
- FULL state with flush=1 and in_valid=1 (data=0xC) → next cycle out_valid=0, out_ctrl=0, 0xC never emitted; stall_cnt unchanged.
- Assert flush and rst together mid-stream → all outputs take reset values, stall_cnt=0.
- CNT_W=4: hold out_ready=0 for 20 cycles with a valid entry → stall_cnt saturates at 15.
